// File: rtl/image_pkg.sv
// image_pkg: shared defaults, pixel width and arbiter state encoding for the image port arbiter.
package image_pkg;
    localparam int DEF_WIDTH_BITS = 8;
    localparam int DEF_HEIGHT_BITS = 8;
    localparam int PIXEL_W = 8;
    typedef enum logic {ARB, LOCKED} arbState_t;
endpackage

// File: rtl/image_port_arbiter_if.sv
// image_port_arbiter_if: requester and ROM-side signals of the image port arbiter.
// Requester side: iReq, iLock, iCol, iRow in; oGrant, oRdValid, oRdData out.
// ROM side: oImageCol, oImageRow out; iImageData in.
// With ARB_STATS_EN defined: iStatsClr in, oGrantCount out (16 bits per requester).
interface image_port_arbiter_if
    import image_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int WIDTH_BITS = DEF_WIDTH_BITS,
    parameter int HEIGHT_BITS = DEF_HEIGHT_BITS
);
    logic [NREQ-1:0] iReq, iLock, oGrant, oRdValid;
    logic [NREQ*WIDTH_BITS-1:0] iCol;
    logic [NREQ*HEIGHT_BITS-1:0] iRow;
    logic [WIDTH_BITS-1:0] oImageCol;
    logic [HEIGHT_BITS-1:0] oImageRow;
    logic [PIXEL_W-1:0] iImageData, oRdData;
`ifdef ARB_STATS_EN
    logic iStatsClr;
    logic [NREQ*16-1:0] oGrantCount;
    modport slave(input iReq, iLock, iCol, iRow, iImageData, iStatsClr,
                  output oGrant, oImageCol, oImageRow, oRdValid, oRdData, oGrantCount);
    modport master(output iReq, iLock, iCol, iRow, iImageData, iStatsClr,
                   input oGrant, oImageCol, oImageRow, oRdValid, oRdData, oGrantCount);
`else
    modport slave(input iReq, iLock, iCol, iRow, iImageData,
                  output oGrant, oImageCol, oImageRow, oRdValid, oRdData);
    modport master(output iReq, iLock, iCol, iRow, iImageData,
                   input oGrant, oImageCol, oImageRow, oRdValid, oRdData);
`endif
endinterface

// File: rtl/image_port_arbiter_rr_pick.sv
// rr_pick: combinational cyclic-priority one-hot selector.
// Ports: req (requests), mask (excluded indices), ptr (highest-priority index) in;
// gnt (one-hot winner, 0 when none) and idx (winner index) out.
module rr_pick #(
    parameter int N = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);
    int j;
    // Scan from the farthest offset down so the candidate nearest ptr wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        j = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j] && !mask[j]) begin
                gnt = '0;
                gnt[j] = 1'b1;
                idx = PW'(j);
            end
        end
    end
endmodule

// File: rtl/image_port_arbiter.sv
// image_port_arbiter: shares a single-read-port image ROM between NREQ requesters.
// Ports: clock, not_reset (async, active-low); bus (image_port_arbiter_if.slave) carries
// requests/locks/addresses in, one-hot grant, ROM address, and the routed pixel with one-hot valid out.
// Round-robin grant with an optional lock held for up to MAX_LOCK grants while others wait.
// Return latency from grant to oRdValid is RD_LATENCY+1 clocks.
// Optional: define ARB_STATS_EN for per-requester saturating grant counters (oGrantCount, iStatsClr).
module image_port_arbiter
    import image_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int WIDTH_BITS = DEF_WIDTH_BITS,
    parameter int HEIGHT_BITS = DEF_HEIGHT_BITS,
    parameter int RD_LATENCY = 1,
    parameter int MAX_LOCK = 16
) (
    input logic clock,
    input logic not_reset,
    image_port_arbiter_if.slave bus
);
    localparam int PW = $clog2(NREQ);
    arbState_t state, stateNext;
    logic [PW-1:0] rrPtr, rrPtrNext, owner, ownerNext, grantIdx, idxAll, idxOther;
    logic [7:0] lockCnt, lockCntNext;
    logic [NREQ-1:0] ownerBit, pickAll, pickOther, grant, tail;
    logic [RD_LATENCY-1:0][NREQ-1:0] pipe;
    logic [WIDTH_BITS-1:0] lastCol;
    logic [HEIGHT_BITS-1:0] lastRow;
    logic ownerGo, breakLock;

    assign ownerBit = NREQ'(1) << owner;
    assign tail = pipe[RD_LATENCY-1];

    rr_pick #(.N(NREQ)) pickA (.req(bus.iReq), .mask('0), .ptr(rrPtr), .gnt(pickAll), .idx(idxAll));
    rr_pick #(.N(NREQ)) pickO (.req(bus.iReq), .mask(ownerBit), .ptr(rrPtr), .gnt(pickOther), .idx(idxOther));

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
    endfunction

    // A saturated lock yields exactly one grant to a waiting requester, then falls back to ARB.
    always_comb begin
        stateNext = ARB;
        rrPtrNext = rrPtr;
        ownerNext = owner;
        lockCntNext = '0;
        breakLock = lockCnt == 8'(MAX_LOCK) && |(bus.iReq & ~ownerBit);
        ownerGo = state == LOCKED && bus.iReq[owner];
        grant = pickAll;
        grantIdx = idxAll;
        if (ownerGo && !breakLock) begin
            grant = ownerBit;
            grantIdx = owner;
            stateNext = bus.iLock[owner] ? LOCKED : ARB;
            lockCntNext = !bus.iLock[owner] ? '0 : (lockCnt == 8'(MAX_LOCK)) ? lockCnt : lockCnt + 8'd1;
        end else if (ownerGo) begin
            grant = pickOther;
            grantIdx = idxOther;
            rrPtrNext = nextPtr(idxOther);
        end else if (|pickAll) begin
            rrPtrNext = nextPtr(idxAll);
            stateNext = bus.iLock[idxAll] ? LOCKED : ARB;
            ownerNext = bus.iLock[idxAll] ? idxAll : owner;
            lockCntNext = bus.iLock[idxAll] ? 8'd1 : 8'd0;
        end
    end

    // Without a grant the ROM address stays on the last granted one to avoid needless toggling.
    assign bus.oGrant = not_reset ? grant : '0;
    assign bus.oImageCol = !not_reset ? '0 : |grant ? bus.iCol[int'(grantIdx)*WIDTH_BITS +: WIDTH_BITS] : lastCol;
    assign bus.oImageRow = !not_reset ? '0 : |grant ? bus.iRow[int'(grantIdx)*HEIGHT_BITS +: HEIGHT_BITS] : lastRow;

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            state <= ARB;
            rrPtr <= '0;
            owner <= '0;
            lockCnt <= '0;
            lastCol <= '0;
            lastRow <= '0;
            pipe <= '0;
            bus.oRdValid <= '0;
            bus.oRdData <= '0;
        end else begin
            state <= stateNext;
            rrPtr <= rrPtrNext;
            owner <= ownerNext;
            lockCnt <= lockCntNext;
            if (|grant) begin
                lastCol <= bus.oImageCol;
                lastRow <= bus.oImageRow;
            end
            for (int k = RD_LATENCY - 1; k > 0; k--) pipe[k] <= pipe[k-1];
            pipe[0] <= grant;
            bus.oRdValid <= tail;
            if (|tail) bus.oRdData <= bus.iImageData;
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) bus.oGrantCount <= '0;
        else
            for (int k = 0; k < NREQ; k++)
                bus.oGrantCount[k*16 +: 16] <= bus.iStatsClr ? 16'd0 :
                    (grant[k] && bus.oGrantCount[k*16 +: 16] != 16'hFFFF) ? bus.oGrantCount[k*16 +: 16] + 16'd1 :
                    bus.oGrantCount[k*16 +: 16];
    end
`endif
endmodule

// File: tb/tb_image_port_arbiter.sv
// tb_image_port_arbiter: directed self-checking bench for image_port_arbiter (NREQ=2, RD_LATENCY=2, MAX_LOCK=16).
module tb_image_port_arbiter;
    import image_pkg::*;
    localparam int L = 2;
    logic clock = 1'b0;
    logic not_reset = 1'b0;
    int checks = 0;
    int failures = 0;
    int cycNo = 0;
    logic [1:0] histG [L+1];
    logic [7:0] histD [L+1];
    logic [15:0] romPipe [L];

    always #5 clock = ~clock;

    image_port_arbiter_if #(.NREQ(2), .WIDTH_BITS(8), .HEIGHT_BITS(8)) bus ();
    image_port_arbiter #(.NREQ(2), .WIDTH_BITS(8), .HEIGHT_BITS(8), .RD_LATENCY(L), .MAX_LOCK(16))
        dut (.clock(clock), .not_reset(not_reset), .bus(bus));

    function automatic logic [7:0] romVal(input logic [7:0] row, input logic [7:0] col);
        return row ^ col ^ 8'h83;
    endfunction

    always @(posedge clock) begin
        romPipe[0] <= {bus.oImageRow, bus.oImageCol};
        for (int k = 1; k < L; k++) romPipe[k] <= romPipe[k-1];
    end
    assign bus.iImageData = romVal(romPipe[L-1][15:8], romPipe[L-1][7:0]);

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clearHist();
        for (int k = 0; k <= L; k++) begin
            histG[k] = '0;
            histD[k] = '0;
        end
    endtask

    // Called at posedge+1: drive, check at negedge, then advance to the next posedge+1.
    task automatic runCycle(input logic [1:0] req, input logic [1:0] lock, input logic [7:0] col0,
                            input logic [7:0] row0, input logic [7:0] col1, input logic [7:0] row1,
                            input logic [1:0] expGrant);
        bus.iReq = req;
        bus.iLock = lock;
        bus.iCol = {col1, col0};
        bus.iRow = {row1, row0};
        @(negedge clock);
        checkEq($sformatf("grant@%0d", cycNo), bus.oGrant, expGrant);
        checkEq($sformatf("valid@%0d", cycNo), bus.oRdValid, histG[L]);
        if (histG[L] != 2'b00) checkEq($sformatf("data@%0d", cycNo), bus.oRdData, histD[L]);
        for (int k = L; k > 0; k--) begin
            histG[k] = histG[k-1];
            histD[k] = histD[k-1];
        end
        histG[0] = expGrant;
        histD[0] = expGrant[1] ? romVal(row1, col1) : romVal(row0, col0);
        cycNo++;
        @(posedge clock);
        #1;
    endtask

    task automatic rc(input logic [1:0] req, input logic [1:0] lock, input logic [1:0] expGrant);
        runCycle(req, lock, 8'(cycNo), 8'(cycNo) ^ 8'h5A, 8'(cycNo) + 8'h80, ~8'(cycNo), expGrant);
    endtask

    initial begin
        bus.iReq = 2'b11;
        bus.iLock = '0;
        bus.iCol = 16'h5555;
        bus.iRow = 16'hAAAA;
`ifdef ARB_STATS_EN
        bus.iStatsClr = 1'b0;
`endif
        clearHist();
        #2;
        checkEq("rstGrant", bus.oGrant, 2'b00);
        checkEq("rstValid", bus.oRdValid, 2'b00);
        checkEq("rstData", bus.oRdData, 8'h00);
        checkEq("rstCol", bus.oImageCol, 8'h00);
        checkEq("rstRow", bus.oImageRow, 8'h00);
        @(posedge clock);
        #1;
        not_reset = 1'b1;
        runCycle(2'b01, 2'b00, 8'h12, 8'h34, 8'h00, 8'h00, 2'b01);
        repeat (4) rc(2'b00, 2'b00, 2'b00);
        checkEq("holdCol", bus.oImageCol, 8'h12);
        checkEq("holdRow", bus.oImageRow, 8'h34);
        rc(2'b11, 2'b00, 2'b10);
        rc(2'b11, 2'b00, 2'b01);
        rc(2'b11, 2'b00, 2'b10);
        rc(2'b11, 2'b00, 2'b01);
        repeat (3) rc(2'b00, 2'b00, 2'b00);
        repeat (20) rc(2'b01, 2'b01, 2'b01);
        rc(2'b11, 2'b01, 2'b10);
        rc(2'b01, 2'b01, 2'b01);
        rc(2'b11, 2'b01, 2'b01);
        rc(2'b11, 2'b01, 2'b01);
        rc(2'b11, 2'b00, 2'b01);
        rc(2'b11, 2'b00, 2'b10);
        rc(2'b01, 2'b01, 2'b01);
        rc(2'b10, 2'b00, 2'b10);
        repeat (3) rc(2'b00, 2'b00, 2'b00);
        rc(2'b10, 2'b00, 2'b10);
        rc(2'b10, 2'b00, 2'b10);
        repeat (4) rc(2'b00, 2'b00, 2'b00);
        rc(2'b11, 2'b00, 2'b01);
        rc(2'b11, 2'b00, 2'b10);
        rc(2'b11, 2'b00, 2'b01);
        bus.iReq = 2'b11;
        not_reset = 1'b0;
        repeat (2) begin
            @(negedge clock);
            checkEq("midRstGrant", bus.oGrant, 2'b00);
            checkEq("midRstValid", bus.oRdValid, 2'b00);
            @(posedge clock);
            #1;
        end
        not_reset = 1'b1;
        clearHist();
        rc(2'b11, 2'b00, 2'b01);
        rc(2'b11, 2'b00, 2'b10);
        repeat (4) rc(2'b00, 2'b00, 2'b00);
`ifdef ARB_STATS_EN
        bus.iStatsClr = 1'b1;
        rc(2'b00, 2'b00, 2'b00);
        bus.iStatsClr = 1'b0;
        repeat (5) rc(2'b01, 2'b00, 2'b01);
        repeat (3) rc(2'b10, 2'b00, 2'b10);
        checkEq("count0", bus.oGrantCount[15:0], 16'd5);
        checkEq("count1", bus.oGrantCount[31:16], 16'd3);
        bus.iStatsClr = 1'b1;
        rc(2'b01, 2'b00, 2'b01);
        bus.iStatsClr = 1'b0;
        checkEq("clrCount0", bus.oGrantCount[15:0], 16'd0);
        checkEq("clrCount1", bus.oGrantCount[31:16], 16'd0);
        repeat (4) rc(2'b00, 2'b00, 2'b00);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/image_port_arbiter.md
Name: image_port_arbiter

Overview:
- Shares the single-read-port image ROM between NREQ pixel requesters, e.g. the box filter and threshold stages running concurrently or overlapped.
- Grants one requester per cycle: round-robin, with an optional raster-run lock bounded by MAX_LOCK.
- Drives the ROM column/row address, then routes the returning pixel to the owning requester with a one-hot valid, RD_LATENCY cycles later.

Parameters:
- NREQ, 2, number of requesters (2..4).
- WIDTH_BITS, 8, column address width.
- HEIGHT_BITS, 8, row address width.
- RD_LATENCY, 1, ROM address-to-data latency in clocks (1..3).
- MAX_LOCK, 16, maximum consecutive locked grants to one requester while another requester is pending (2..255).

Ports:
- clock  in  1  system clock
- not_reset  in  1  reset, asynchronous, active-low
- iReq  in  NREQ  per-requester read request, level
- iLock  in  NREQ  requester asks to keep the grant next cycle
- iCol  in  NREQ*WIDTH_BITS  packed column addresses; requester i at slice [i*WIDTH_BITS +: WIDTH_BITS]
- iRow  in  NREQ*HEIGHT_BITS  packed row addresses, same packing
- oGrant  out  NREQ  one-hot grant, same cycle as request
- oImageCol  out  WIDTH_BITS  ROM column address
- oImageRow  out  HEIGHT_BITS  ROM row address
- iImageData  in  8  ROM read data
- oRdValid  out  NREQ  one-hot: oRdData belongs to requester i
- oRdData  out  8  registered pixel data

Behaviour:
- Reset (async): rr_ptr=0, lock_owner=none, lock_cnt=0, valid pipeline cleared, oRdValid=0, oRdData=0. While not_reset is low, oGrant=0 and oImageCol/oImageRow=0.
- oGrant is combinational from iReq, rr_ptr and lock state. At most one bit is set; it is 0 when iReq=0.
- Address mux: oImageCol/oImageRow = granted requester's slice. With no grant, they hold the last granted address (registered copy; no spurious ROM toggling).
- A request is accepted in the cycle its oGrant bit is 1. The requester may change address or deassert on the next cycle.
- States:
  - ARB: grant the first requesting index at or after rr_ptr (cyclic). On a grant to i: rr_ptr<=(i+1) mod NREQ. If iLock[i]=1, go to LOCKED with owner=i and lock_cnt=1.
  - LOCKED: if iReq[owner]=1, grant owner and increment lock_cnt (saturates at MAX_LOCK).
    - Stay in LOCKED while iLock[owner]=1, and either lock_cnt<MAX_LOCK or no other iReq is set.
    - If iReq[owner]=0 or iLock[owner]=0 when the grant is taken: return to ARB. If iReq[owner]=0, arbitrate normally in that same cycle, no dead cycle.
    - If lock_cnt==MAX_LOCK and another requester is pending: that cycle's grant goes to the round-robin winner excluding the owner; return to ARB; lock_cnt=0.
- Return path: shift register of depth RD_LATENCY carrying the one-hot grant. oRdData<=iImageData is captured when the pipeline tail is nonzero and held otherwise. oRdValid is the tail, registered with the data. Net latency from grant to oRdValid = RD_LATENCY+1 cycles.
- Back-to-back grants give one valid per cycle, in grant order.
- A requester dropping iReq mid-flight still receives its outstanding valids.
- Reset mid-operation discards in-flight reads; no valid is issued after reset.

Optional Feature:
- ARB_STATS_EN.
- Defined: adds output oGrantCount[NREQ*16-1:0], one saturating 16-bit counter per requester, incremented on each grant. Also adds input iStatsClr: synchronous clear, which takes priority over increment in the same cycle. Counters reset to 0.
- Undefined: no counters and no ports; the remaining behaviour is identical.

Decomposition:
- Shared package image_pkg holds: WIDTH_BITS/HEIGHT_BITS defaults, PIXEL_W=8, and the arbiter state enum {ARB, LOCKED}.
- One sub-module, rr_pick: combinational cyclic-priority one-hot selector taking (req, ptr, mask), reused for both the normal pick and the lock-break pick.

Test Plan:
- Single requester: iReq=01, iCol0=0x12, iRow0=0x34, ROM[0x34][0x12]=0xA5 -> oGrant=01 same cycle; oRdValid=01, oRdData=0xA5 RD_LATENCY+1 cycles later.
- Both requesting continuously, no lock -> grants alternate 01,10,01,10; valids follow in the same order; rr_ptr wraps correctly.
- Requester 0 locked, requester 1 idle for 40 cycles -> 40 consecutive grants to 0. Requester 1 raises iReq at cycle 20 with MAX_LOCK=16 -> exactly one grant to 1 at the break, then the lock is re-acquired by 0 via ARB.
- Requester 1 drops iReq with 2 reads outstanding (RD_LATENCY=2) -> both oRdValid=10 pulses still delivered with correct data.
- not_reset asserted with 3 reads in flight, released 2 cycles later -> no oRdValid; oGrant=0 during reset; rr_ptr=0 afterwards, so simultaneous requests grant requester 0 first.
- ARB_STATS_EN defined: 5 grants to 0 and 3 grants to 1 -> counts 5 and 3. iStatsClr together with a grant -> count 0.
